// File: rtl/seg_display_pkg.sv
// seg_display_pkg: shared FSM states and hex-to-segment table for the display arbiter
package seg_display_pkg;
  typedef enum logic [1:0] {IDLE = 2'd0, OWN0 = 2'd1, OWN1 = 2'd2} state_t;
  localparam logic [6:0] SEG_BLANK = 7'h7F;
  // index 0 is the last entry; active-low gfedcba
  localparam logic [15:0][6:0] HEX_SEG = {
    7'b0001110, 7'b0000110, 7'b0100001, 7'b1000110,
    7'b0000011, 7'b0001000, 7'b0010000, 7'b0000000,
    7'b1111000, 7'b0000010, 7'b0010010, 7'b0011001,
    7'b0110000, 7'b0100100, 7'b1111001, 7'b1000000
  };
endpackage

// File: rtl/seg_display_arbiter_scan.sv
// seg_scan: free-running digit strobe rotation, one strobe per SCAN_DIV clocks
module seg_scan #(
  parameter int SCAN_DIV = 400000
) (
  input  logic       i_clk,
  input  logic       i_rst_n,
  output logic [3:0] o_led_digit
);
  localparam int SW = $clog2(SCAN_DIV);
  logic [SW-1:0] scan_cnt;
  logic          terminal;
  assign terminal = scan_cnt == SW'(SCAN_DIV - 1);
  always_ff @(posedge i_clk or negedge i_rst_n)
    if (!i_rst_n) begin
      scan_cnt    <= '0;
      o_led_digit <= 4'b1110;
    end else begin
      scan_cnt    <= terminal ? '0 : scan_cnt + 1'b1;
      o_led_digit <= terminal ? {o_led_digit[2:0], o_led_digit[3]} : o_led_digit;
    end
endmodule

// File: rtl/seg_display_arbiter.sv
// seg_display_arbiter: round-robin display ownership with minimum hold and hex segment mux
// Define SEG_LEADING_ZERO_BLANK_EN to blank leading zero digits (digit 0 always lit).
module seg_display_arbiter
  import seg_display_pkg::*;
#(
  parameter int SCAN_DIV    = 400000,
  parameter int HOLD_CYCLES = 10000000
) (
  input  logic        i_clk,
  input  logic        i_rst_n,
  input  logic [1:0]  i_req,
  input  logic [15:0] i_data0,
  input  logic [15:0] i_data1,
  output logic [1:0]  o_grant,
  output logic [6:0]  o_led_segment,
  output logic [3:0]  o_led_digit,
  output logic [3:0]  o_led_digit_unused
);
  localparam int HW = $clog2(HOLD_CYCLES + 1);
  localparam logic [HW-1:0] HOLD_LOAD = HW'(HOLD_CYCLES - 1);
  state_t        state, state_n;
  logic          last_owner, last_n, own;
  logic [HW-1:0] hold_cnt, hold_n;
  logic [15:0]   data;
  logic [1:0]    idx;
  logic          valid, blank;
  logic [3:0]    nib;

  seg_scan #(.SCAN_DIV(SCAN_DIV)) u_scan (
    .i_clk      (i_clk),
    .i_rst_n    (i_rst_n),
    .o_led_digit(o_led_digit)
  );

  assign o_grant            = {state == OWN1, state == OWN0};
  assign o_led_digit_unused = 4'b1111;

  always_ff @(posedge i_clk or negedge i_rst_n)
    if (!i_rst_n) begin
      state      <= IDLE;
      last_owner <= 1'b1;
      hold_cnt   <= '0;
    end else begin
      state      <= state_n;
      last_owner <= last_n;
      hold_cnt   <= hold_n;
    end

  always_comb begin
    state_n = state;
    last_n  = last_owner;
    hold_n  = hold_cnt != '0 ? hold_cnt - 1'b1 : hold_cnt;
    own     = state == OWN1;
    if (state == IDLE)
      state_n = i_req == 2'b11 ? (last_owner ? OWN0 : OWN1) :
                i_req[0]       ? OWN0 :
                i_req[1]       ? OWN1 : IDLE;
    else if (hold_cnt == '0)
      state_n = i_req[~own] ? (own ? OWN0 : OWN1) : i_req[own] ? state : IDLE;
    // a fresh grant or a same-owner renewal both restart the hold window
    if (state_n != IDLE && (state_n != state || hold_cnt == '0)) begin
      hold_n = HOLD_LOAD;
      last_n = state_n == OWN1;
    end
  end

  always_comb begin
    data  = state == OWN1 ? i_data1 : i_data0;
    valid = 1'b1;
    idx   = 2'd0;
    case (o_led_digit)
      4'b1110: idx = 2'd0;
      4'b1101: idx = 2'd1;
      4'b1011: idx = 2'd2;
      4'b0111: idx = 2'd3;
      default: valid = 1'b0;
    endcase
    nib = data[{idx, 2'b00} +: 4];
`ifdef SEG_LEADING_ZERO_BLANK_EN
    blank = idx != 2'd0 && (data >> {idx, 2'b00}) == 16'h0000;
`else
    blank = 1'b0;
`endif
    o_led_segment = (state == IDLE || !valid || blank) ? SEG_BLANK : HEX_SEG[nib];
  end
endmodule

// File: tb/tb_seg_display_arbiter.sv
// tb_seg_display_arbiter: directed + random stimulus against a cycle-count reference model
module tb_seg_display_arbiter;
  localparam int SCAN = 4;
  localparam int HOLD = 8;
  logic        clk = 1'b0;
  logic        rst_n;
  logic [1:0]  req;
  logic [15:0] d0, d1;
  logic [1:0]  grant;
  logic [6:0]  seg;
  logic [3:0]  digit, unused;
  int errors = 0;
  int checks = 0;
  int m_own, m_last, m_age, m_cyc;
  logic [6:0] hex_tab [16] = '{
    7'b1000000, 7'b1111001, 7'b0100100, 7'b0110000,
    7'b0011001, 7'b0010010, 7'b0000010, 7'b1111000,
    7'b0000000, 7'b0010000, 7'b0001000, 7'b0000011,
    7'b1000110, 7'b0100001, 7'b0000110, 7'b0001110
  };

  seg_display_arbiter #(.SCAN_DIV(SCAN), .HOLD_CYCLES(HOLD)) dut (
    .i_clk(clk), .i_rst_n(rst_n), .i_req(req), .i_data0(d0), .i_data1(d1),
    .o_grant(grant), .o_led_segment(seg), .o_led_digit(digit),
    .o_led_digit_unused(unused)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  function automatic void model_reset();
    m_own = -1; m_last = 1; m_age = 0; m_cyc = 0;
  endfunction

  function automatic void grant_to(input int r);
    m_own = r; m_last = r; m_age = 0;
  endfunction

  // one rising edge of the arbitration rules, expressed as owned-cycle age
  function automatic void model_step();
    if (m_own < 0) begin
      if (req == 2'b11) grant_to(1 - m_last);
      else if (req[0]) grant_to(0);
      else if (req[1]) grant_to(1);
    end else if (m_age == HOLD - 1) begin
      if (req[1 - m_own]) grant_to(1 - m_own);
      else if (req[m_own]) m_age = 0;
      else m_own = -1;
    end else m_age++;
    m_cyc++;
  endfunction

  function automatic int exp_idx();
    return (m_cyc / SCAN) % 4;
  endfunction

  function automatic logic [6:0] exp_seg();
    logic [15:0] v;
    if (m_own < 0) return 7'h7F;
    v = (m_own == 1 ? d1 : d0) >> (4 * exp_idx());
`ifdef SEG_LEADING_ZERO_BLANK_EN
    if (exp_idx() != 0 && v == 16'h0) return 7'h7F;
`endif
    return hex_tab[v[3:0]];
  endfunction

  task automatic check_all(input string tag);
    chk({tag, "_grant"}, 16'(grant), m_own < 0 ? 16'h0 : 16'(1 << m_own));
    chk({tag, "_digit"}, 16'(digit), 16'(~(4'b0001 << exp_idx()) & 4'hF));
    chk({tag, "_seg"}, 16'(seg), 16'(exp_seg()));
  endtask

  task automatic tick(input string tag);
    @(posedge clk);
    model_step();
    #1;
    check_all(tag);
  endtask

  task automatic ticks(input string tag, input int n);
    for (int i = 0; i < n; i++) tick(tag);
  endtask

  task automatic do_reset(input string tag);
    @(negedge clk);
    #1 rst_n = 1'b0;
    #1;
    model_reset();
    chk({tag, "_rst_grant"}, 16'(grant), 16'h0);
    chk({tag, "_rst_digit"}, 16'(digit), 16'hE);
    chk({tag, "_rst_seg"}, 16'(seg), 16'h7F);
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  initial begin
    rst_n = 1'b1; req = 2'b00; d0 = 16'h0; d1 = 16'h0;
    #2 rst_n = 1'b0;
    #1;
    model_reset();
    chk("t1_grant", 16'(grant), 16'h0);
    chk("t1_digit", 16'(digit), 16'hE);
    chk("t1_seg", 16'(seg), 16'h7F);
    chk("t1_unused", 16'(unused), 16'hF);
    @(negedge clk);
    rst_n = 1'b1;
    ticks("t1_idle", 3);
    do_reset("t2");
    req = 2'b01; d0 = 16'h1234;
    tick("t2");
    chk("t2_first_seg", 16'(seg), 16'(7'b0011001));
    ticks("t2", 18);
    req = 2'b00;
    ticks("t2_drop", 10);
    do_reset("t3");
    req = 2'b11; d0 = 16'h5A5A; d1 = 16'hC3E7;
    tick("t3");
    chk("t3_first", 16'(grant), 16'h1);
    ticks("t3", 40);
    do_reset("t4");
    req = 2'b01;
    tick("t4_grant");
    tick("t4_own2");
    req = 2'b00;
    ticks("t4", 12);
    do_reset("t5");
    req = 2'b10; d1 = 16'hABCD;
    ticks("t5", 4);
    do_reset("t5_mid");
    req = 2'b11;
    tick("t5_tie");
    chk("t5_tie_grant", 16'(grant), 16'h1);
    ticks("t5_after", 6);
    do_reset("t6");
    req = 2'b01; d0 = 16'h0042;
    ticks("t6_0042", 16);
    d0 = 16'h0000;
    ticks("t6_0000", 16);
    do_reset("rnd");
    for (int i = 0; i < 300; i++) begin
      req = 2'($urandom_range(0, 3));
      if ($urandom_range(0, 3) == 0) begin
        d0 = 16'($urandom) >> (4 * $urandom_range(0, 3));
        d1 = 16'($urandom) >> (4 * $urandom_range(0, 3));
        #1;
        chk("rnd_comb_seg", 16'(seg), 16'(exp_seg()));
      end
      tick("rnd");
    end
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule

// File: doc/seg_display_arbiter.md
# seg_display_arbiter

Shares the board's single 4-digit multiplexed 7-segment display between two requesters, e.g. the stopwatch counter and the UART receive-byte monitor. A three-state FSM grants display ownership with round-robin fairness and a minimum hold time. A free-running scanner drives the digit strobes and hex-decodes the owner's 16-bit value onto the segment lines. It sits between the requesting blocks and the top-level display pins.

## Interface
- `SCAN_DIV`, default 400000: clocks per digit strobe; must be ≥ 2.
- `HOLD_CYCLES`, default 10000000: minimum ownership duration in clocks; must be ≥ 1.
- `i_clk`, input, 1: system clock.
- `i_rst_n`, input, 1: reset, asynchronous, active-low.
- `i_req`, input, 2: bit n high means requester n wants the display.
- `i_data0`, input, 16: requester 0 value as four hex nibbles; [3:0] is the rightmost digit.
- `i_data1`, input, 16: requester 1 value, same format.
- `o_grant`, output, 2: one-hot owner, registered; 00 means no owner.
- `o_led_segment`, output, 7: active-low segments, bit order gfedcba.
- `o_led_digit`, output, 4: active-low one-hot digit strobe, registered.
- `o_led_digit_unused`, output, 4: tied to 4'b1111.

## Operation
- **FSM states:** IDLE, OWN0, OWN1. `o_grant` is decoded from the state register: 00, 01, 10.
- **IDLE:**
  - Only `i_req[0]` high: go to OWN0.
  - Only `i_req[1]` high: go to OWN1.
  - Both high: go to the requester that is not `last_owner`.
  - Neither high: stay in IDLE.
- **Entering OWNx:** load `hold_cnt` with HOLD_CYCLES-1 and set `last_owner` to x.
- **In OWNx:** `hold_cnt` decrements each cycle while non-zero. Requests are ignored until `hold_cnt` equals 0.
- **At `hold_cnt` == 0 in OWNx:**
  - Other requester's req high: switch to OWN(other). Round-robin has priority over the current owner.
  - Otherwise, own req high: stay in OWNx and reload `hold_cnt`.
  - Otherwise: go to IDLE.
- **Direct switching:** OWN0 goes straight to OWN1 (and back) without passing through IDLE.
- **Scanner:**
  - `scan_cnt` counts 0..SCAN_DIV-1 and runs in every state.
  - On the terminal count, `o_led_digit` rotates as {[2:0],[3]}.
  - Strobe 1110 shows nibble [3:0], 1101 shows [7:4], 1011 shows [11:8], 0111 shows [15:12].
- **Segment path:** `o_led_segment` is combinational from `o_led_digit`, the state and the live data of the owner.
  - IDLE: all segments off, 7'h7F.
  - Hex decode, active low: 0=1000000, 1=1111001, 2=0100100, 3=0110000, 4=0011001, 5=0010010, 6=0000010, 7=1111000, 8=0000000, 9=0010000, A=0001000, b=0000011, C=1000110, d=0100001, E=0000110, F=0001110.
  - An invalid strobe pattern outputs 7'h7F.
- **Counter widths:**
  - `hold_cnt` is $clog2(HOLD_CYCLES+1) bits.
  - `scan_cnt` is $clog2(SCAN_DIV) bits.
  - Neither counter wraps below 0.

## Timing
- **Reset values** (asynchronous, taking effect immediately, including mid-ownership): state IDLE, `o_grant` 00, `last_owner` 1 (so requester 0 wins the first tie), `hold_cnt` 0, `scan_cnt` 0, `o_led_digit` 1110, `o_led_segment` 7'h7F.
- **Grant latency:** a request sampled in IDLE produces the grant on the next clock edge, i.e. 1 cycle.
- **Minimum ownership:** exactly HOLD_CYCLES cycles between grant assertion and the earliest possible owner change.
- **Data latency:** a data change reaches the segments in the same cycle (combinational path); there is no data latching.
- **Digit period:** each strobe is held for SCAN_DIV cycles; one full frame is 4×SCAN_DIV cycles.

## Configuration
- Macro: `SEG_LEADING_ZERO_BLANK_EN`.
- **Defined:** leading zero nibbles of the owner's data, counted from digit 3 downward, display 7'h7F. Digit 0 is never blanked.
- **Undefined:** all four nibbles are always decoded.

## Structure
- **Package `seg_display_pkg`:** FSM state enum typedef, 16-entry hex-to-segment constant table, SEG_BLANK = 7'h7F.
- **Sub-module `seg_scan`:** `scan_cnt` plus the digit-strobe rotation; parameter SCAN_DIV, ports `i_clk`, `i_rst_n`, `o_led_digit`.
- **Top level:** FSM, hold counter and segment mux.

## Test plan
All scenarios use SCAN_DIV=4 and HOLD_CYCLES=8.
1. Assert reset without clock edges → `o_grant`=00, `o_led_digit`=1110 and `o_led_segment`=7'h7F take effect immediately.
2. `i_req`=01, `i_data0`=16'h1234 → `o_grant`=01 one cycle later. Strobe 1110 shows 0011001, and each strobe advances every 4 cycles through 0110000, 0100100, 1111001.
3. From IDLE, `i_req`=11 held → `o_grant`=01 for 8 cycles, then 10 for 8 cycles, then 01, alternating.
4. OWN0 with `i_req` dropped to 00 at the 2nd owned cycle → `o_grant` stays 01 for all 8 cycles, then 00, with segments at 7'h7F.
5. OWN1 with `i_data1`=16'hABCD, async reset pulsed mid-hold → outputs return to reset values immediately. After release with `i_req`=11, requester 0 is granted first.
6. Macro defined, `i_data0`=16'h0042 → digits 3 and 2 show 7'h7F, digit 1 shows 0011001, digit 0 shows 0100100. With 16'h0000, only digit 0 is lit (1000000).
